// File: rtl/per_handshake_arbiter.sv
// Round-robin owner of one four-phase send/ack peripheral link shared by two requesters.
// Runs send-high / ack-high / send-low / ack-low, then pulses done or err to the granted side.
module per_handshake_arbiter #(
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              ctl_clk,
  input  logic              ctl_rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] dados0,
  output logic              done0,
  output logic              err0,
  input  logic              req1,
  input  logic [DATA_W-1:0] dados1,
  output logic              done1,
  output logic              err1,
  output logic              per_send,
  input  logic              per_ack,
  output logic [DATA_W-1:0] per_dados,
  output logic              busy,
  output logic              grant,
  output logic [2:0]        state_dbg
);

  // Handshake: a requester raises req (level) with dados valid and holds both until
  // its done/err pulse; the peripheral link is four-phase, per_send and per_ack
  // each return to 0 before the next transfer.

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd4;

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             pick;

  // Single requester wins outright; on a tie the one not served last time wins.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_grant;
  end

  always_ff @(posedge ctl_clk) begin
    if (ctl_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      per_send   <= 1'b0;
      per_dados  <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            grant      <= pick;
            last_grant <= pick;
            per_dados  <= pick ? dados1 : dados0;
            per_send   <= 1'b1;
            cnt        <= '0;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (per_ack) begin
            per_send <= 1'b0;
            cnt      <= '0;
            state    <= ST_RELEASE;
          end else if (cnt == CNT_LAST) begin
            per_send <= 1'b0;
            state    <= ST_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!per_ack) begin
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            state <= ST_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: begin
          per_send <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done0     = (state == ST_DONE) && !grant;
  assign done1     = (state == ST_DONE) &&  grant;
  assign err0      = (state == ST_ERR)  && !grant;
  assign err1      = (state == ST_ERR)  &&  grant;
  assign state_dbg = state;

endmodule
